relu_chunk_sequencer: RTL and testbench
=======================================

Name: relu_chunk_sequencer

Overview:
- Sequences one full layer's pre-activation vector through the shared NUM_LANES-wide ReLU stage, one lane-chunk at a time.
- Holds the layer vector and collects the activated results in place.
- Presents the assembled vector downstream with a valid/ready handshake.
- Sits between a layer's accumulator output and the next layer's input.

Parameters:
- DATA_WIDTH, 16, bits per neuron value (two's complement).
- NUM_NEURONS, 12, neurons in the layer vector.
- NUM_LANES, 3, lane count of the ReLU stage it drives.
- NUM_CHUNKS, ceil(NUM_NEURONS/NUM_LANES), derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- IN_VALID  in  1  upstream vector valid.
- IN_READY  out  1  sequencer can accept a vector.
- IN_BITS  in  DATA_WIDTH*NUM_NEURONS  neuron n at bits [n*DATA_WIDTH +: DATA_WIDTH].
- RELU_IN_VALID  out  1  one-cycle pulse per chunk to the ReLU stage.
- RELU_IN_BITS  out  DATA_WIDTH*NUM_LANES  chunk to the ReLU stage; lane l = neuron chunk_idx*NUM_LANES+l.
- RELU_OUT_VALID  in  1  ReLU result valid.
- RELU_OUT_BITS  in  DATA_WIDTH*NUM_LANES  ReLU results, same lane order.
- OUT_VALID  out  1  assembled vector valid.
- OUT_READY  in  1  downstream accepts.
- OUT_BITS  out  DATA_WIDTH*NUM_NEURONS  activated vector, same packing as IN_BITS.
- BUSY  out  1  high in any state other than IDLE.
- CHUNK_IDX  out  max(1,clog2(NUM_CHUNKS))  current chunk, for debug.

Behaviour:
- All outputs are registered.
- On rst: state=IDLE; IN_READY=0; RELU_IN_VALID=0; OUT_VALID=0; BUSY=0; CHUNK_IDX=0; RELU_IN_BITS=0; OUT_BITS=0; input buffer cleared.
- IN_READY rises in the first cycle after rst deasserts.
- IDLE: IN_READY=1.
  - When IN_VALID&IN_READY is sampled, capture IN_BITS into the input buffer, set CHUNK_IDX=0, drop IN_READY, go to ISSUE.
- ISSUE (1 cycle): register RELU_IN_BITS from input-buffer chunk CHUNK_IDX, assert RELU_IN_VALID for exactly this cycle, go to WAIT.
  - Pad lanes (neuron index >= NUM_NEURONS) are driven 0.
  - RELU_IN_BITS holds its value until the next ISSUE.
- WAIT: idle until RELU_OUT_VALID is sampled high. Then:
  - write each lane l to OUT_BITS slot CHUNK_IDX*NUM_LANES+l; pad lanes are discarded.
  - if CHUNK_IDX==NUM_CHUNKS-1, go to DONE; otherwise increment CHUNK_IDX and go to ISSUE.
  - There is no timeout: WAIT holds indefinitely.
- DONE: OUT_VALID=1, with OUT_BITS stable.
  - OUT_READY low holds DONE indefinitely.
  - When OUT_VALID&OUT_READY is sampled, clear OUT_VALID, go to IDLE, and assert IN_READY the next cycle.
- Timing with the standard ReLU stage (RELU_OUT_VALID two cycles after RELU_IN_VALID): 3 cycles per chunk.
  - Input accepted in cycle a gives first RELU_IN_VALID in cycle a+1.
  - OUT_VALID first high in cycle a+1+3*NUM_CHUNKS.
- Ignored events:
  - IN_VALID outside IDLE; the input buffer is not overwritten.
  - RELU_OUT_VALID outside WAIT (stray pulse).
  - OUT_READY outside DONE.
- In DONE, if IN_VALID and OUT_READY are high together, the vector is NOT accepted that cycle; it is accepted at the earliest in the cycle after the return to IDLE.
- rst mid-operation (any state) aborts immediately to reset values. A RELU_OUT_VALID arriving after reset release lands in IDLE and is ignored.
- Only one ReLU transaction is in flight at a time; RELU_IN_VALID never re-asserts before the previous RELU_OUT_VALID.

Test Plan:
1. Defaults; IN_BITS neurons 0..11 = {5,-3,0,7,-1,32767,-32768,2,-2,100,-100,1}; OUT_READY=1 → exactly 4 RELU_IN_VALID pulses. OUT_BITS = {5,0,0,7,0,32767,0,2,0,100,0,1}. OUT_VALID at cycle a+13, high for one cycle.
2. NUM_NEURONS=10, NUM_LANES=3, all inputs -5 except neuron 9=9 → 4 chunks. Chunk 3 RELU_IN_BITS lanes 1,2 = 0. OUT_BITS = nine 0s then 9; no write beyond slot 9.
3. OUT_READY held 0 for 20 cycles after OUT_VALID → OUT_VALID and OUT_BITS stable; IN_READY=0; a new IN_VALID is ignored. Release OUT_READY → IDLE, then the new vector is accepted.
4. Stray RELU_OUT_VALID pulse in IDLE, in ISSUE, and in DONE → no state or buffer change; the subsequent normal vector result is correct.
5. Assert rst in WAIT of chunk 2 → all outputs 0 asynchronously; after release IN_READY=1 the next cycle. A late RELU_OUT_VALID is ignored; a fresh vector completes correctly.
6. Back-to-back vectors with IN_VALID held high and OUT_READY=1 → second vector accepted in the cycle after the IDLE re-entry. Both outputs are correct, with no chunk mixing.

Source files
------------

// File: rtl/relu_chunk_sequencer.sv
// rtl/relu_chunk_sequencer.sv - streams a layer vector through a shared NUM_LANES-wide ReLU stage chunk by chunk
module relu_chunk_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_NEURONS = 12,
  parameter int NUM_LANES   = 3,
  localparam int NUM_CHUNKS = (NUM_NEURONS + NUM_LANES - 1) / NUM_LANES,
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              IN_VALID,
  output logic                              IN_READY,
  input  logic [DATA_WIDTH*NUM_NEURONS-1:0] IN_BITS,
  output logic                              RELU_IN_VALID,
  output logic [DATA_WIDTH*NUM_LANES-1:0]   RELU_IN_BITS,
  input  logic                              RELU_OUT_VALID,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]   RELU_OUT_BITS,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic [DATA_WIDTH*NUM_NEURONS-1:0] OUT_BITS,
  output logic                              BUSY,
  output logic [IDX_W-1:0]                  CHUNK_IDX
);

  localparam int VEC_BITS   = DATA_WIDTH * NUM_NEURONS;
  localparam int CHUNK_BITS = DATA_WIDTH * NUM_LANES;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  state_q;
  logic                    in_ready_q;
  logic                    relu_in_valid_q;
  logic [CHUNK_BITS-1:0]   relu_in_bits_q;
  logic                    out_valid_q;
  logic [VEC_BITS-1:0]     out_bits_q;
  logic [VEC_BITS-1:0]     in_buf_q;
  logic                    busy_q;
  logic [IDX_W-1:0]        chunk_idx_q;
  logic [IDX_W-1:0]        chunk_inc_d;
  logic                    last_chunk_d;

  assign chunk_inc_d  = chunk_idx_q + IDX_W'(1);
  assign last_chunk_d = (chunk_idx_q == IDX_W'(NUM_CHUNKS - 1));

  // Lanes that fall past the last neuron stay zero.
  function automatic logic [CHUNK_BITS-1:0] chunk_of(input logic [VEC_BITS-1:0] vec,
                                                     input logic [IDX_W-1:0]    idx);
    logic [CHUNK_BITS-1:0] r;
    r = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (IDX_W'(n / NUM_LANES) == idx)
        r[(n % NUM_LANES)*DATA_WIDTH +: DATA_WIDTH] = vec[n*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      in_ready_q      <= 1'b0;
      relu_in_valid_q <= 1'b0;
      relu_in_bits_q  <= '0;
      out_valid_q     <= 1'b0;
      out_bits_q      <= '0;
      in_buf_q        <= '0;
      busy_q          <= 1'b0;
      chunk_idx_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (IN_VALID && in_ready_q) begin
            in_buf_q        <= IN_BITS;
            chunk_idx_q     <= '0;
            in_ready_q      <= 1'b0;
            relu_in_bits_q  <= chunk_of(IN_BITS, '0);
            relu_in_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          relu_in_valid_q <= 1'b0;
          state_q         <= S_WAIT;
        end
        S_WAIT: begin
          if (RELU_OUT_VALID) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
              if (IDX_W'(n / NUM_LANES) == chunk_idx_q)
                out_bits_q[n*DATA_WIDTH +: DATA_WIDTH] <=
                  RELU_OUT_BITS[(n % NUM_LANES)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (last_chunk_d) begin
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              chunk_idx_q     <= chunk_inc_d;
              relu_in_bits_q  <= chunk_of(in_buf_q, chunk_inc_d);
              relu_in_valid_q <= 1'b1;
              state_q         <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          // IN_READY comes back together with IDLE so a waiting vector is taken one cycle later.
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IN_READY      = in_ready_q;
  assign RELU_IN_VALID = relu_in_valid_q;
  assign RELU_IN_BITS  = relu_in_bits_q;
  assign OUT_VALID     = out_valid_q;
  assign OUT_BITS      = out_bits_q;
  assign BUSY          = busy_q;
  assign CHUNK_IDX     = chunk_idx_q;

endmodule

// File: tb/tb_relu_chunk_sequencer.sv
// tb/tb_relu_chunk_sequencer.sv - directed self-checking bench for relu_chunk_sequencer
module tb_relu_chunk_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 1: default 12 neurons x 3 lanes
  logic         in_valid, in_ready, relu_in_valid, relu_out_valid, out_valid, out_ready, busy;
  logic [191:0] in_bits, out_bits;
  logic [47:0]  relu_in_bits, relu_out_bits;
  logic [1:0]   chunk_idx;
  logic         stray;

  // Instance 2: 10 neurons x 3 lanes
  logic         in_valid2, in_ready2, relu_in_valid2, relu_out_valid2, out_valid2, out_ready2, busy2;
  logic [159:0] in_bits2, out_bits2;
  logic [47:0]  relu_in_bits2, relu_out_bits2;
  logic [1:0]   chunk_idx2;

  relu_chunk_sequencer u_dut (
    .clk(clk), .rst(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_BITS(in_bits),
    .RELU_IN_VALID(relu_in_valid), .RELU_IN_BITS(relu_in_bits),
    .RELU_OUT_VALID(relu_out_valid), .RELU_OUT_BITS(relu_out_bits),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_BITS(out_bits),
    .BUSY(busy), .CHUNK_IDX(chunk_idx)
  );

  relu_chunk_sequencer #(.DATA_WIDTH(16), .NUM_NEURONS(10), .NUM_LANES(3)) u_dut10 (
    .clk(clk), .rst(rst),
    .IN_VALID(in_valid2), .IN_READY(in_ready2), .IN_BITS(in_bits2),
    .RELU_IN_VALID(relu_in_valid2), .RELU_IN_BITS(relu_in_bits2),
    .RELU_OUT_VALID(relu_out_valid2), .RELU_OUT_BITS(relu_out_bits2),
    .OUT_VALID(out_valid2), .OUT_READY(out_ready2), .OUT_BITS(out_bits2),
    .BUSY(busy2), .CHUNK_IDX(chunk_idx2)
  );

  // Two-cycle ReLU stage model; deliberately not reset so late responses still arrive.
  function automatic logic [47:0] relu3(input logic [47:0] x);
    logic [47:0] r;
    for (int l = 0; l < 3; l++) r[l*16 +: 16] = x[l*16+15] ? 16'h0000 : x[l*16 +: 16];
    return r;
  endfunction

  logic        rv1 = 1'b0, rv2 = 1'b0, rv1b = 1'b0, rv2b = 1'b0;
  logic [47:0] rd1 = '0, rd2 = '0, rd1b = '0, rd2b = '0;
  always @(posedge clk) begin
    rv1 <= relu_in_valid;   rd1 <= relu3(relu_in_bits);
    rv2 <= rv1;             rd2 <= rd1;
    rv1b <= relu_in_valid2; rd1b <= relu3(relu_in_bits2);
    rv2b <= rv1b;           rd2b <= rd1b;
  end
  assign relu_out_valid  = rv2 | stray;
  assign relu_out_bits   = stray ? 48'h1111_2222_3333 : rd2;
  assign relu_out_valid2 = rv2b;
  assign relu_out_bits2  = rd2b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(output int steps, output int pulses);
    steps = 0;
    pulses = 0;
    while (!out_valid && steps < 200) begin
      if (relu_in_valid) pulses++;
      step();
      steps++;
    end
    chk("done_reached", out_valid, 1'b1);
  endtask

  localparam logic [191:0] V1 = 192'h0001_FF9C_0064_FFFE_0002_8000_7FFF_FFFF_0007_0000_FFFD_0005;
  localparam logic [191:0] E1 = 192'h0001_0000_0064_0000_0002_0000_7FFF_0000_0007_0000_0000_0005;
  localparam logic [191:0] V3 = 192'h000C_FFF5_000A_FFF7_0008_FFF9_0006_FFFB_0004_FFFD_0002_FFFF;
  localparam logic [191:0] E3 = 192'h000C_0000_000A_0000_0008_0000_0006_0000_0004_0000_0002_0000;
  localparam logic [191:0] V4 = 192'h1234_8001_0FFF_F000_0010_FFF0_0100_FF00_4000_C000_0001_8000;
  localparam logic [191:0] E4 = 192'h1234_0000_0FFF_0000_0010_0000_0100_0000_4000_0000_0001_0000;
  localparam logic [191:0] V6A = 192'h00CC_00BB_00AA_0099_0088_0077_0066_0055_0044_0033_0022_0011;
  localparam logic [191:0] V6B = 192'h7000_FFFF_7000_FFFF_7000_FFFF_7000_FFFF_7000_FFFF_7000_FFFF;
  localparam logic [191:0] E6B = 192'h7000_0000_7000_0000_7000_0000_7000_0000_7000_0000_7000_0000;
  localparam logic [159:0] V2 = 160'h0009_FFFB_FFFB_FFFB_FFFB_FFFB_FFFB_FFFB_FFFB_FFFB;
  localparam logic [159:0] E2 = 160'h0009_0000_0000_0000_0000_0000_0000_0000_0000_0000;

  initial begin
    int steps, pulses;
    rst = 1'b1;
    in_valid = 1'b0;  in_bits = '0;  out_ready = 1'b1;  stray = 1'b0;
    in_valid2 = 1'b0; in_bits2 = '0; out_ready2 = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_relu_in_valid", relu_in_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_chunk_idx", chunk_idx, 2'd0);
    chk("rst_relu_in_bits", relu_in_bits, 48'h0);
    chk("rst_out_bits", out_bits, 192'h0);
    rst = 1'b0;
    chk("in_ready_low_at_release", in_ready, 1'b0);
    step();
    chk("in_ready_after_release", in_ready, 1'b1);

    // 1: default vector, cycle timing and pulse count
    in_valid = 1'b1; in_bits = V1;
    step();
    in_valid = 1'b0;
    chk("t1_first_issue", relu_in_valid, 1'b1);
    chk("t1_chunk0_bits", relu_in_bits, 48'h0000_FFFD_0005);
    chk("t1_in_ready_drop", in_ready, 1'b0);
    chk("t1_busy", busy, 1'b1);
    run_to_done(steps, pulses);
    chk("t1_out_valid_cycle", steps, 12);
    chk("t1_pulses", pulses, 4);
    chk("t1_out_bits", out_bits, E1);
    step();
    chk("t1_out_valid_one_cycle", out_valid, 1'b0);
    chk("t1_in_ready_back", in_ready, 1'b1);
    chk("t1_busy_idle", busy, 1'b0);

    // 2: ten neurons, padded last chunk
    in_valid2 = 1'b1; in_bits2 = V2;
    step();
    in_valid2 = 1'b0;
    chk("t2_chunk0_bits", relu_in_bits2, 48'hFFFB_FFFB_FFFB);
    for (int k = 0; k < 40; k++) begin
      if (relu_in_valid2 && chunk_idx2 == 2'd3) break;
      step();
    end
    chk("t2_chunk3_issue", {relu_in_valid2, chunk_idx2}, 3'b1_11);
    chk("t2_chunk3_pad_bits", relu_in_bits2, 48'h0000_0000_0009);
    for (int k = 0; k < 40; k++) begin
      if (out_valid2) break;
      step();
    end
    chk("t2_done", out_valid2, 1'b1);
    chk("t2_out_bits", out_bits2, E2);
    step();

    // 3: downstream backpressure, new vector ignored in DONE
    out_ready = 1'b0;
    in_valid = 1'b1; in_bits = V3;
    step();
    in_valid = 1'b0;
    run_to_done(steps, pulses);
    in_valid = 1'b1; in_bits = V4;
    for (int k = 0; k < 20; k++) begin
      chk("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_bits", out_bits, E3);
      chk("t3_hold_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t3_release_out_valid", out_valid, 1'b0);
    chk("t3_release_in_ready", in_ready, 1'b1);
    chk("t3_not_accepted_in_done", busy, 1'b0);
    step();
    in_valid = 1'b0;
    chk("t3_new_issue", relu_in_valid, 1'b1);
    chk("t3_new_chunk0", relu_in_bits, 48'hC000_0001_8000);
    run_to_done(steps, pulses);
    chk("t3_new_out_bits", out_bits, E4);
    step();

    // 6: back-to-back with IN_VALID held high
    in_valid = 1'b1; in_bits = V6A;
    step();
    in_bits = V6B;
    chk("t6_a_chunk0", relu_in_bits, 48'h0033_0022_0011);
    run_to_done(steps, pulses);
    chk("t6_a_cycle", steps, 12);
    chk("t6_a_out_bits", out_bits, V6A);
    step();
    chk("t6_reentry_in_ready", in_ready, 1'b1);
    chk("t6_reentry_out_valid", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    chk("t6_b_issue", relu_in_valid, 1'b1);
    chk("t6_b_chunk0", relu_in_bits, 48'hFFFF_7000_FFFF);
    run_to_done(steps, pulses);
    chk("t6_b_cycle", steps, 12);
    chk("t6_b_out_bits", out_bits, E6B);
    step();

    // 4: stray RELU_OUT_VALID in IDLE, ISSUE and DONE
    stray = 1'b1;
    step();
    stray = 1'b0;
    chk("t4_idle_busy", busy, 1'b0);
    chk("t4_idle_in_ready", in_ready, 1'b1);
    chk("t4_idle_out_bits", out_bits, E6B);
    chk("t4_idle_relu_in_valid", relu_in_valid, 1'b0);
    in_valid = 1'b1; in_bits = V1;
    step();
    in_valid = 1'b0;
    stray = 1'b1;
    step();
    stray = 1'b0;
    chk("t4_issue_chunk_idx", chunk_idx, 2'd0);
    chk("t4_issue_no_reissue", relu_in_valid, 1'b0);
    step();
    step();
    chk("t4_second_issue", {relu_in_valid, chunk_idx}, 3'b1_01);
    out_ready = 1'b0;
    run_to_done(steps, pulses);
    stray = 1'b1;
    step();
    stray = 1'b0;
    chk("t4_done_out_valid", out_valid, 1'b1);
    chk("t4_done_out_bits", out_bits, E1);
    chk("t4_done_busy", busy, 1'b1);
    out_ready = 1'b1;
    step();

    // 5: reset during WAIT of chunk 2
    in_valid = 1'b1; in_bits = V1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (relu_in_valid && chunk_idx == 2'd2) break;
      step();
    end
    chk("t5_chunk2_issue", {relu_in_valid, chunk_idx}, 3'b1_10);
    step();
    #4;
    rst = 1'b1;
    #1;
    chk("t5_async_in_ready", in_ready, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_chunk_idx", chunk_idx, 2'd0);
    chk("t5_async_relu_in_bits", relu_in_bits, 48'h0);
    chk("t5_async_out_bits", out_bits, 192'h0);
    chk("t5_async_out_valid", out_valid, 1'b0);
    #1;
    rst = 1'b0;
    step();
    chk("t5_in_ready_after_release", in_ready, 1'b1);
    step();
    chk("t5_late_resp_busy", busy, 1'b0);
    chk("t5_late_resp_out_bits", out_bits, 192'h0);
    chk("t5_late_resp_chunk_idx", chunk_idx, 2'd0);
    in_valid = 1'b1; in_bits = V3;
    step();
    in_valid = 1'b0;
    run_to_done(steps, pulses);
    chk("t5_fresh_cycle", steps, 12);
    chk("t5_fresh_out_bits", out_bits, E3);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
